// File: rtl/small_buffer_sparse_encoder.sv
// small_buffer_sparse_encoder
//   Captures one dense block of BITMASK_LENGTH elements and streams its
//   nonzero elements out, NUM_OUTPUT lanes per beat, in ascending index order,
//   together with the block's nonzero bitmask.
//
// Ports
//   clock          sole clock, rising edge
//   resetn         asynchronous active-low reset
//   ivalid/oready  upstream block handshake; denseBlock holds element i at
//                  bits [(i+1)*ELEMENT_WIDTH-1 -: ELEMENT_WIDTH]
//   ovalid/iready  downstream beat handshake
//   bitmask        bit i set iff element i of the captured block is nonzero
//   packedOutput   this beat's nonzero elements starting at lane 0, unused lanes 0
//   numValidOutput number of valid lanes in this beat (0..NUM_OUTPUT)
//   isFirstBeat / isLastBeat  beat position within the block
//
// Build option
//   SMALL_BUFFER_ENCODER_BACK_TO_BACK_EN: when defined, oready follows iready
//   during a block's last beat so the next block is captured with no bubble.
//   When undefined, one IDLE cycle separates consecutive blocks.
module small_buffer_sparse_encoder #(
  parameter int BITMASK_LENGTH = 8,
  parameter int ELEMENT_WIDTH  = 16,
  parameter int NUM_OUTPUT     = 2,
  parameter int INDEX_BITWIDTH = $clog2(BITMASK_LENGTH) + 1,
  parameter int COUNT_BITWIDTH = $clog2(NUM_OUTPUT) + 1
) (
  input  logic                                    clock,
  input  logic                                    resetn,
  input  logic                                    ivalid,
  output logic                                    oready,
  input  logic [BITMASK_LENGTH*ELEMENT_WIDTH-1:0] denseBlock,
  output logic                                    ovalid,
  input  logic                                    iready,
  output logic [BITMASK_LENGTH-1:0]               bitmask,
  output logic [NUM_OUTPUT*ELEMENT_WIDTH-1:0]     packedOutput,
  output logic [COUNT_BITWIDTH-1:0]               numValidOutput,
  output logic                                    isFirstBeat,
  output logic                                    isLastBeat
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [0:0]                              r_state;
  logic                                    r_rst_done;
  logic [BITMASK_LENGTH*ELEMENT_WIDTH-1:0] r_data;
  logic [BITMASK_LENGTH-1:0]               r_bitmask;
  logic [INDEX_BITWIDTH-1:0]               r_index;
  logic [INDEX_BITWIDTH-1:0]               r_remaining;
  logic                                    r_first;

  logic [BITMASK_LENGTH-1:0]               w_in_mask;
  logic [INDEX_BITWIDTH-1:0]               w_in_nnz;
  logic [NUM_OUTPUT*ELEMENT_WIDTH-1:0]     w_lanes;
  logic [COUNT_BITWIDTH-1:0]               w_cnt;
  logic [INDEX_BITWIDTH-1:0]               w_next_idx;
  logic                                    w_emit;
  logic                                    w_last;
  logic                                    w_accept;
  logic                                    w_fire;

  // Bitmask and nonzero count of the incoming block.
  always_comb begin
    w_in_mask = '0;
    w_in_nnz  = '0;
    for (int unsigned i = 0; i < BITMASK_LENGTH; i++) begin
      if (denseBlock[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] != '0) begin
        w_in_mask[i] = 1'b1;
        w_in_nnz     = w_in_nnz + INDEX_BITWIDTH'(1);
      end
    end
  end

  // Gather up to NUM_OUTPUT nonzero elements at or after the search index;
  // w_next_idx lands one past the last element taken.
  always_comb begin
    w_lanes    = '0;
    w_cnt      = '0;
    w_next_idx = r_index;
    for (int unsigned i = 0; i < BITMASK_LENGTH; i++) begin
      if ((INDEX_BITWIDTH'(i) >= r_index) && r_bitmask[i] &&
          (w_cnt < COUNT_BITWIDTH'(NUM_OUTPUT))) begin
        w_lanes[w_cnt*ELEMENT_WIDTH +: ELEMENT_WIDTH] = r_data[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
        w_cnt      = w_cnt + COUNT_BITWIDTH'(1);
        w_next_idx = INDEX_BITWIDTH'(i + 1);
      end
    end
  end

  assign w_emit = (r_state == S_EMIT);
  // An all-zero block has remaining=0 and is therefore a single (last) beat.
  assign w_last = (r_remaining <= INDEX_BITWIDTH'(NUM_OUTPUT));

`ifdef SMALL_BUFFER_ENCODER_BACK_TO_BACK_EN
  assign oready = ((r_state == S_IDLE) && r_rst_done) || (w_emit && w_last && iready);
`else
  assign oready = (r_state == S_IDLE) && r_rst_done;
`endif

  assign w_accept = oready && ivalid;
  assign w_fire   = w_emit && iready;

  assign ovalid         = w_emit;
  assign bitmask        = w_emit ? r_bitmask : '0;
  assign packedOutput   = w_emit ? w_lanes   : '0;
  assign numValidOutput = w_emit ? w_cnt     : '0;
  assign isFirstBeat    = w_emit && r_first;
  assign isLastBeat     = w_emit && w_last;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_rst_done  <= 1'b0;
      r_data      <= '0;
      r_bitmask   <= '0;
      r_index     <= '0;
      r_remaining <= '0;
      r_first     <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      // Capture takes priority: with back-to-back enabled it coincides with
      // the last-beat handshake and replaces the finished block in place.
      if (w_accept) begin
        r_state     <= S_EMIT;
        r_data      <= denseBlock;
        r_bitmask   <= w_in_mask;
        r_remaining <= w_in_nnz;
        r_index     <= '0;
        r_first     <= 1'b1;
      end else if (w_fire) begin
        if (w_last) begin
          r_state <= S_IDLE;
        end else begin
          r_index     <= w_next_idx;
          r_remaining <= r_remaining - INDEX_BITWIDTH'(w_cnt);
          r_first     <= 1'b0;
        end
      end
    end
  end

endmodule
